// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_responder
// Purpose  : I2C target. SCL/SDA are oversampled with MCLK (no clock
//            stretching). The block detects START / repeated START / STOP,
//            matches a 7-bit address and ACKs it. Write bytes are handed to
//            the host on RX_DATA/RX_VALID. Read bytes are fetched from the
//            host through the TX_REQ/TX_DATA handshake.
// Ports    : MCLK      system clock, at least 8x SCL
//            nRST      asynchronous active-low reset
//            SRST      synchronous reset, same effect as nRST
//            SCL_IN    raw bus clock pin
//            SDA_IN    raw bus data pin
//            SDA_OUT   open-drain control (0 = pull low, 1 = release)
//            RX_ACK    1 = ACK received data bytes, 0 = NACK them
//            TX_DATA   next read byte, loaded at the SCL fall after TX_REQ
//            RX_DATA   last received write byte
//            RX_VALID  1-cycle pulse, RX_DATA updated
//            TX_REQ    1-cycle pulse requesting the next TX_DATA
//            ADDR_HIT  1-cycle pulse on address match
//            RW        R/W bit of the last matched address (1 = read)
//            START_DET 1-cycle pulse on START / repeated START
//            STOP_DET  1-cycle pulse on STOP
//            BUSY      high from START until STOP
//            STATUS    current state code
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_responder #(
  parameter logic [6:0] ADDR = 7'h68
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       SRST,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  input  logic       RX_ACK,
  input  logic [7:0] TX_DATA,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       TX_REQ,
  output logic       ADDR_HIT,
  output logic       RW,
  output logic       START_DET,
  output logic       STOP_DET,
  output logic       BUSY,
  output logic [2:0] STATUS
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  // Two-flop synchronizers plus a previous-sample flop for edge detection.
  // These are cleared only by nRST: after SRST the synchronized history stays
  // valid, so releasing SRST mid-transfer cannot fabricate a START or STOP.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL_IN};
      sda_sync <= {sda_sync[0], SDA_IN};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  logic scl, sda;
  logic start_cond, stop_cond, scl_rise, scl_fall;

  assign scl        = scl_sync[1];
  assign sda        = sda_sync[1];
  assign start_cond = scl_prev & scl & sda_prev & ~sda;
  assign stop_cond  = scl_prev & scl & ~sda_prev & sda;
  assign scl_rise   = ~scl_prev & scl;
  assign scl_fall   = scl_prev & ~scl;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       sda_drv, sda_drv_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, addr_hit_n, rw_n;
  logic       start_det_n, stop_det_n, busy_n;

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      sda_drv   <= 1'b1;
      SDA_OUT   <= 1'b1;
      RX_DATA   <= 8'd0;
      RX_VALID  <= 1'b0;
      TX_REQ    <= 1'b0;
      ADDR_HIT  <= 1'b0;
      RW        <= 1'b0;
      START_DET <= 1'b0;
      STOP_DET  <= 1'b0;
      BUSY      <= 1'b0;
    end else if (SRST) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      sda_drv   <= 1'b1;
      SDA_OUT   <= 1'b1;
      RX_DATA   <= 8'd0;
      RX_VALID  <= 1'b0;
      TX_REQ    <= 1'b0;
      ADDR_HIT  <= 1'b0;
      RW        <= 1'b0;
      START_DET <= 1'b0;
      STOP_DET  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      sda_drv   <= sda_drv_n;
      // Extra stage: the pin follows the FSM decision one cycle later.
      SDA_OUT   <= sda_drv;
      RX_DATA   <= rx_data_n;
      RX_VALID  <= rx_valid_n;
      TX_REQ    <= tx_req_n;
      ADDR_HIT  <= addr_hit_n;
      RW        <= rw_n;
      START_DET <= start_det_n;
      STOP_DET  <= stop_det_n;
      BUSY      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    sda_drv_n   = sda_drv;
    rx_data_n   = RX_DATA;
    rw_n        = RW;
    busy_n      = BUSY;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;
    addr_hit_n  = 1'b0;
    start_det_n = 1'b0;
    stop_det_n  = 1'b0;

    if (start_cond) begin
      state_n     = S_ADDR;
      bit_cnt_n   = 4'd0;
      sda_drv_n   = 1'b1;
      busy_n      = 1'b1;
      start_det_n = 1'b1;
    end else if (stop_cond) begin
      state_n    = S_IDLE;
      sda_drv_n  = 1'b1;
      busy_n     = 1'b0;
      stop_det_n = 1'b1;
    end else begin
      case (state)
        S_ADDR: begin
          // The fall that completes the START itself arrives with bit_cnt 0
          // and is ignored here.
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == ADDR) begin
              sda_drv_n  = 1'b0;
              addr_hit_n = 1'b1;
              rw_n       = shift[0];
              state_n    = S_ADDR_ACK;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) begin
            tx_req_n = RW;
          end else if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (RW) begin
              shift_n   = TX_DATA;
              sda_drv_n = TX_DATA[7];
              state_n   = S_TX;
            end else begin
              sda_drv_n = 1'b1;
              state_n   = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data_n  = {shift[6:0], sda};
              rx_valid_n = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_drv_n = ~RX_ACK;
            state_n   = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_drv_n = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = S_RX;
          end
        end
        S_TX: begin
          // shift[7] is already on the bus; each fall advances one bit until
          // all eight have been clocked out by the master.
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_drv_n = 1'b1;
              bit_cnt_n = 4'd0;
              state_n   = S_TX_ACK;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_drv_n = shift[6];
            end
          end
        end
        S_TX_ACK: begin
          // A NACK leaves on the rise, so a fall seen here always follows ACK.
          if (scl_rise) begin
            if (sda) begin
              state_n = S_IGNORE;
            end else begin
              tx_req_n = 1'b1;
            end
          end else if (scl_fall) begin
            shift_n   = TX_DATA;
            sda_drv_n = TX_DATA[7];
            bit_cnt_n = 4'd0;
            state_n   = S_TX;
          end
        end
        default: begin
          sda_drv_n = 1'b1;
        end
      endcase
    end
  end

  assign STATUS = state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_responder
// Purpose  : Self-checking bench for i2c_slave_responder. A bus master model
//            drives SCL/SDA (wired-AND with the target's SDA_OUT), a host
//            model answers TX_REQ, and transaction-level expectations are
//            computed from the protocol rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_responder;

  localparam int Q = 5;  // MCLK cycles per SCL quarter period

  logic       MCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       SRST = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       SDA_OUT;
  logic       RX_ACK = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic [7:0] RX_DATA;
  logic       RX_VALID, TX_REQ, ADDR_HIT, RW, START_DET, STOP_DET, BUSY;
  logic [2:0] STATUS;

  assign sda_bus = m_sda & SDA_OUT;

  always #5 MCLK = ~MCLK;

  i2c_slave_responder dut (
    .MCLK(MCLK), .nRST(nRST), .SRST(SRST), .SCL_IN(scl), .SDA_IN(sda_bus),
    .SDA_OUT(SDA_OUT), .RX_ACK(RX_ACK), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .TX_REQ(TX_REQ), .ADDR_HIT(ADDR_HIT), .RW(RW),
    .START_DET(START_DET), .STOP_DET(STOP_DET), .BUSY(BUSY), .STATUS(STATUS)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event monitor and host model
  int         n_hit = 0, n_rxv = 0, n_txreq = 0, n_start = 0, n_stop = 0, n_glitch = 0;
  logic [7:0] rx_q[$];
  logic       rw_q[$];
  logic [7:0] tx_src[$];
  logic       last_sda_out = 1'b1;

  always @(negedge MCLK) begin
    if (nRST) begin
      if (ADDR_HIT) begin n_hit++; rw_q.push_back(RW); end
      if (RX_VALID) begin n_rxv++; rx_q.push_back(RX_DATA); end
      if (TX_REQ) begin
        n_txreq++;
        if (tx_src.size() > 0) TX_DATA = tx_src.pop_front();
        else TX_DATA = 8'hEE;
      end
      if (START_DET) n_start++;
      if (STOP_DET) n_stop++;
      if (SDA_OUT !== last_sda_out && scl) n_glitch++;
    end
    last_sda_out = SDA_OUT;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Bus master primitives
  task automatic wq();
    repeat (Q) @(negedge MCLK);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(); scl = 1'b1; wq(); m_sda = 1'b0; wq(); scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(); scl = 1'b1; wq(); m_sda = 1'b1; wq();
  endtask

  task automatic do_bit(input logic b, output logic seen);
    m_sda = b; wq(); scl = 1'b1; wq(); seen = sda_bus; wq(); scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_lvl);
    logic dummy;
    for (int i = 7; i >= 0; i--) do_bit(b[i], dummy);
    do_bit(1'b1, ack_lvl);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] data);
    logic dummy;
    for (int i = 7; i >= 0; i--) do_bit(1'b1, data[i]);
    do_bit(ack_bit, dummy);
  endtask

  // Transaction records and reference model
  typedef struct {
    logic [7:0]      addr;
    int              n;
    logic [3:0][7:0] d;
    logic            rx_ack;
    int              exp_hits;
    int              exp_rxv;
    int              exp_txreq;
    logic            exp_lvl;   // bus level during the address ACK clock
  } vec_t;

  function automatic vec_t mk(input logic [7:0] addr, input int n, input logic [7:0] d0,
                              input logic [7:0] d1, input logic rx_ack, input int hits,
                              input int rxv, input int txreq, input logic lvl);
    vec_t v;
    v.addr = addr; v.n = n; v.d = '0; v.d[0] = d0; v.d[1] = d1; v.rx_ack = rx_ack;
    v.exp_hits = hits; v.exp_rxv = rxv; v.exp_txreq = txreq; v.exp_lvl = lvl;
    return v;
  endfunction

  function automatic logic is_match(input logic [7:0] addr);
    return addr[7:1] == 7'h68;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic m = is_match(v.addr);
    r.exp_lvl   = !m;
    r.exp_hits  = m ? 1 : 0;
    r.exp_rxv   = (m && !v.addr[0]) ? v.n : 0;
    r.exp_txreq = (m && v.addr[0]) ? v.n : 0;
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int         h0, r0, t0, s0, p0;
    logic       lvl, m;
    logic [7:0] rd;
    h0 = n_hit; r0 = n_rxv; t0 = n_txreq; s0 = n_start; p0 = n_stop;
    m = is_match(v.addr);
    rx_q.delete(); rw_q.delete(); tx_src.delete();
    RX_ACK = v.rx_ack;
    if (v.addr[0]) for (int i = 0; i < v.n; i++) tx_src.push_back(v.d[i]);
    bus_start();
    write_byte(v.addr, lvl);
    check("addr_ack", lvl, v.exp_lvl);
    check("busy_mid", BUSY, 1);
    for (int i = 0; i < v.n; i++) begin
      if (v.addr[0]) begin
        read_byte((i == v.n - 1), rd);
        check("rd_byte", rd, m ? v.d[i] : 8'hFF);
      end else begin
        write_byte(v.d[i], lvl);
        check("wr_ack", lvl, m ? !v.rx_ack : 1'b1);
      end
    end
    check("sda_released", SDA_OUT, 1);
    bus_stop();
    repeat (8) @(negedge MCLK);
    check("addr_hit_cnt", n_hit - h0, v.exp_hits);
    check("rx_valid_cnt", n_rxv - r0, v.exp_rxv);
    check("tx_req_cnt", n_txreq - t0, v.exp_txreq);
    check("start_cnt", n_start - s0, 1);
    check("stop_cnt", n_stop - p0, 1);
    check("busy_end", BUSY, 0);
    check("status_end", STATUS, 0);
    if (m) check("rw", RW, v.addr[0]);
    if (m && !v.addr[0] && rx_q.size() == v.n)
      for (int i = 0; i < v.n; i++) check("rx_data", rx_q[i], v.d[i]);
  endtask

  vec_t tbl[6];

  initial begin
    logic       lvl, seen;
    logic [7:0] rd;
    int         r0, t0, s0;
    vec_t       v;

    tbl[0] = mk(8'hD0, 2, 8'h75, 8'h3C, 1'b1, 1, 2, 0, 1'b0);
    tbl[1] = mk(8'hD1, 2, 8'hA5, 8'h5A, 1'b1, 1, 0, 2, 1'b0);
    tbl[2] = mk(8'hA0, 1, 8'h11, 8'h00, 1'b1, 0, 0, 0, 1'b1);
    tbl[3] = mk(8'hD0, 1, 8'h42, 8'h00, 1'b0, 1, 1, 0, 1'b0);
    tbl[4] = mk(8'hD1, 1, 8'h3C, 8'h00, 1'b1, 1, 0, 1, 1'b0);
    tbl[5] = mk(8'hD3, 1, 8'h77, 8'h00, 1'b1, 0, 0, 0, 1'b1);

    repeat (4) @(negedge MCLK);
    nRST = 1'b1;
    repeat (2) @(negedge MCLK);
    check("rst_sda_out", SDA_OUT, 1);
    check("rst_rx_data", RX_DATA, 0);
    check("rst_pulses", {RX_VALID, TX_REQ, ADDR_HIT, START_DET, STOP_DET}, 0);
    check("rst_rw_busy", {RW, BUSY}, 0);
    check("rst_status", STATUS, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Write then repeated START into a one-byte read
    r0 = n_rxv; t0 = n_txreq; s0 = n_start;
    rx_q.delete(); rw_q.delete(); tx_src.delete(); tx_src.push_back(8'hC3);
    RX_ACK = 1'b1;
    bus_start();
    write_byte(8'hD0, lvl); check("sr_addr_w_ack", lvl, 0);
    write_byte(8'h75, lvl); check("sr_data_ack", lvl, 0);
    bus_start();
    write_byte(8'hD1, lvl); check("sr_addr_r_ack", lvl, 0);
    read_byte(1'b1, rd);    check("sr_rd_byte", rd, 8'hC3);
    bus_stop();
    repeat (8) @(negedge MCLK);
    check("sr_start_cnt", n_start - s0, 2);
    check("sr_rw_cnt", rw_q.size(), 2);
    if (rw_q.size() == 2) begin
      check("sr_rw_first", rw_q[0], 0);
      check("sr_rw_second", rw_q[1], 1);
    end
    check("sr_rx_data", RX_DATA, 8'h75);
    check("sr_rxv_cnt", n_rxv - r0, 1);
    check("sr_txreq_cnt", n_txreq - t0, 1);

    // STOP after four data bits aborts the byte
    r0 = n_rxv;
    bus_start();
    write_byte(8'hD0, lvl); check("ab_addr_ack", lvl, 0);
    for (int i = 0; i < 4; i++) do_bit(i[0], seen);
    bus_stop();
    repeat (8) @(negedge MCLK);
    check("ab_rxv_cnt", n_rxv - r0, 0);
    check("ab_status", STATUS, 0);
    check("ab_rx_data_kept", RX_DATA, 8'h75);

    // SRST while the target pulls SDA low in S_TX
    tx_src.delete(); tx_src.push_back(8'h00);
    bus_start();
    write_byte(8'hD1, lvl); check("sr2_addr_ack", lvl, 0);
    do_bit(1'b1, seen);     check("sr2_bit7", seen, 0);
    check("sr2_pre_sda", SDA_OUT, 0);
    check("sr2_pre_status", STATUS, 5);
    SRST = 1'b1;
    @(negedge MCLK);
    check("sr2_sda_out", SDA_OUT, 1);
    check("sr2_status", STATUS, 0);
    SRST = 1'b0;
    do_bit(1'b1, seen);     check("sr2_ignored", seen, 1);
    bus_stop();
    repeat (8) @(negedge MCLK);
    check("sr2_busy", BUSY, 0);

    // Randomized transactions against the reference model
    for (int k = 0; k < 12; k++) begin
      int sel;
      v = mk(8'h00, 1, 8'h00, 8'h00, 1'b1, 0, 0, 0, 1'b1);
      sel = int'($urandom_range(0, 3));
      if (sel == 0) v.addr = 8'hD0;
      else if (sel == 1) v.addr = 8'hD1;
      else v.addr = 8'($urandom());
      v.n = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) v.d[i] = 8'($urandom());
      v.rx_ack = ($urandom_range(0, 3) != 0);
      run_vec(model(v));
    end

    check("no_sda_change_while_scl_high", n_glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

I2C target (slave) that answers the bus master on the same two-wire bus, oversampling SCL/SDA with MCLK. No TIC input and no clock stretching. It detects START, repeated START and STOP, matches a 7-bit address and ACKs it. Write bytes go to the host as RX_DATA/RX_VALID; read bytes come from the host through a TX_REQ/TX_DATA handshake. Used to bench the master and as an on-chip target for the sensor subsystem.

## Interface
- ADDR, 7'h68, 7-bit target address.
- MCLK  in  1  system clock; must be at least 8× SCL frequency.
- nRST  in  1  reset, asynchronous, active-low.
- SRST  in  1  synchronous reset; same effect as nRST, applied on the next MCLK edge.
- SCL_IN  in  1  bus clock, raw pin.
- SDA_IN  in  1  bus data, raw pin.
- SDA_OUT  out  1  open-drain control: 0 = pull low, 1 = release.
- RX_ACK  in  1  1 = ACK received data bytes, 0 = NACK them.
- TX_DATA  in  8  next read byte; sampled when loaded (see Timing).
- RX_DATA  out  8  last received write byte.
- RX_VALID  out  1  1-cycle pulse, RX_DATA updated.
- TX_REQ  out  1  1-cycle pulse requesting the next TX_DATA.
- ADDR_HIT  out  1  1-cycle pulse on address match.
- RW  out  1  R/W bit of the last matched address (1 = read).
- START_DET, STOP_DET  out  1  1-cycle pulses on START/Sr and STOP.
- BUSY  out  1  high from START until STOP.
- STATUS  out  3  state code.

## Operation
- Inputs pass through a 2-flop synchronizer; a third flop gives the previous sample for edge detection.
- Bus conditions on synchronized signals:
  - START: SDA falls while SCL is high in both previous and current sample.
  - STOP: SDA rises while SCL is high in both samples.
  - Data bits are sampled only on an SCL rising edge.
- States and STATUS codes: S_IDLE 0, S_ADDR 1, S_ADDR_ACK 2, S_RX 3, S_RX_ACK 4, S_TX 5, S_TX_ACK 6, S_IGNORE 7.
- START in any state:
  - bit count 0, SDA_OUT=1, BUSY=1, START_DET pulse, go to S_ADDR.
  - Repeated START is handled the same way.
- STOP in any state: SDA_OUT=1, BUSY=0, STOP_DET pulse, go to S_IDLE.
- START/STOP take priority over all other transitions in the same cycle.
- S_ADDR: shift in 8 bits MSB first. On the SCL fall after bit 8:
  - shift[7:1]==ADDR: SDA_OUT=0, ADDR_HIT pulse, RW=shift[0], go to S_ADDR_ACK.
  - otherwise: go to S_IGNORE, SDA_OUT stays 1.
- S_ADDR_ACK, at the SCL fall ending the ACK clock:
  - RW=0: SDA_OUT=1, go to S_RX.
  - RW=1: load shift from TX_DATA, SDA_OUT=TX_DATA[7], go to S_TX.
- S_RX:
  - On the 8th rise: RX_DATA updated, RX_VALID pulse.
  - On the next fall: SDA_OUT=~RX_ACK, go to S_RX_ACK.
- S_RX_ACK: at the fall ending the ACK clock, SDA_OUT=1, bit count 0, go to S_RX.
- S_TX:
  - Each SCL fall drives the next bit.
  - At the fall ending bit 0: SDA_OUT=1, go to S_TX_ACK.
- S_TX_ACK, SDA sampled on the rise:
  - 0 (master ACK): TX_REQ pulse; on the fall load TX_DATA, drive bit 7, go to S_TX.
  - 1 (master NACK): go to S_IGNORE.
- S_IGNORE: SDA_OUT=1; leave only on START or STOP.
- SDA_OUT changes only while SCL is low, so the target's own drive never produces a false START/STOP.

## Timing
- Reset values (nRST or SRST):
  - SDA_OUT=1, RX_DATA=0, RX_VALID=0, TX_REQ=0, ADDR_HIT=0, RW=0, START_DET=0, STOP_DET=0, BUSY=0, STATUS=0, state S_IDLE.
- Detection latency: pin edge to internal event is 3 MCLK cycles. SDA_OUT registers 1 cycle later, so pin change to SDA_OUT change is 4 MCLK.
- TX_REQ timing:
  - For the first read byte, TX_REQ pulses on the SCL rise of the address ACK clock.
  - For later bytes, it pulses on the rise of the master-ACK clock.
  - TX_DATA must be valid by the following SCL fall detection, giving at least the SCL high time minus 1 cycle.
- RX_VALID asserts 3 cycles after the 8th SCL rise; RX_DATA holds until the next byte.
- A START or STOP mid-byte aborts the byte: no RX_VALID, partial bits discarded.
- Reset mid-transaction: SDA_OUT=1 on the next cycle; the target ignores the bus until the next START.

## Test plan
- Write transfer: START, 0xD0, 0x75, 0x3C, STOP with RX_ACK=1.
  - SDA_OUT=0 during all three 9th clocks.
  - ADDR_HIT once, RW=0.
  - RX_VALID twice, RX_DATA=0x75 then 0x3C.
  - STOP_DET, BUSY=0.
- Read transfer: START, 0xD1, host supplies 0xA5 then 0x5A; master ACKs byte 1 and NACKs byte 2.
  - SDA_OUT serializes 10100101 then 01011010.
  - TX_REQ pulses exactly twice.
  - SDA_OUT=1 after the NACK until STOP.
- Address mismatch: START, 0xA0, 0x11, STOP.
  - SDA_OUT stays 1 throughout; no ADDR_HIT, no RX_VALID.
- Repeated START: 0xD0, 0x75, Sr, 0xD1, read 1 byte with NACK, STOP.
  - START_DET twice, RW goes 0 then 1.
  - RX_DATA=0x75, one TX byte returned.
- RX_ACK=0 during a write byte 0x42: RX_VALID with 0x42, SDA_OUT=1 on its 9th clock.
- Aborts:
  - STOP after 4 data bits: no RX_VALID, state S_IDLE.
  - SRST asserted during S_TX with SDA_OUT=0: SDA_OUT=1 one cycle later, STATUS=0.
